// File: rtl/vga_line_fetch_pkg.sv
// Shared types and constants for the VGA line-fetch block.
// Memory access codes, line-buffer geometry and the latched burst request.
package vga_line_fetch_pkg;

   localparam logic [1:0]  ACC_BURST = 2'd3;
   localparam int unsigned LB_DEPTH  = 512;
   localparam int unsigned PIX_W     = 16;
   localparam int unsigned WORD_W    = 2 * PIX_W;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned BURST_W   = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [1:0]         acc;
      logic [ADDR_W-1:0]  addr;
      logic [BURST_W-1:0] burst;
   } mem_req_t;

   // Two pixels per memory word; an odd pixel count still needs the final word.
   function automatic logic [BURST_W-1:0] words_for(input logic [BURST_W-1:0] pixels);
      return BURST_W'(((BURST_W+1)'(pixels) + (BURST_W+1)'(1)) >> 1);
   endfunction

endpackage

// File: rtl/line_fetch_fifo.sv
// Small synchronous FIFO for returned memory words.
// A push while full and a pop while empty are both ignored.
module line_fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 32
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata_c,
   output logic                   full_c,
   output logic                   empty_c,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   always_comb begin
      full_c  = (count == CW'(DEPTH));
      empty_c = (count == '0);
      push_ok = push && !full_c;
      pop_ok  = pop && !empty_c;
      rdata_c = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/vga_line_fetch.sv
// Fetches one scan line as a memory burst and unpacks 32-bit words into
// 16-bit pixels written sequentially into the line buffer from entry 0.
module vga_line_fetch
   import vga_line_fetch_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LB_AW      = $clog2(LB_DEPTH)
) (
   input  logic               clk,
   input  logic               res,
   input  logic               vga_cs,
   input  logic [ADDR_W-1:0]  vga_addr,
   input  logic [1:0]         vga_acc,
   input  logic [BURST_W-1:0] vga_burst,
   output logic               vga_ack,
   output logic               mem_cs,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [1:0]         mem_acc,
   output logic [BURST_W-1:0] mem_burst,
   input  logic [WORD_W-1:0]  mem_dout,
   input  logic               mem_ack,
   output logic               mem_stall,
   output logic [LB_AW-1:0]   high_ram_addr,
   output logic [PIX_W-1:0]   high_ram_din,
   output logic               high_ram_wr,
   output logic               busy,
   output logic               err
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t             state;
   state_t             state_next;
   mem_req_t           req;
   logic [BURST_W-1:0] word_cnt;
   logic [BURST_W-1:0] pix_left;
   logic [LB_AW-1:0]   wr_ptr;
   logic               half_sel;

   logic               accept_c, bad_req_c, ack_in_c, overflow_c;
   logic               avail_c, wr_c, pop_c, fifo_push_c, fifo_pop_c, stall_c;
   logic [WORD_W-1:0]  head_c, fifo_rdata_c;
   logic               fifo_full_c, fifo_empty_c;
   logic [CNT_W-1:0]   fifo_count, occ_next_c;

   assign mem_acc   = req.acc;
   assign mem_addr  = req.addr;
   assign mem_burst = req.burst;

   line_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
      .clk     (clk),
      .res     (res),
      .push    (fifo_push_c),
      .pop     (fifo_pop_c),
      .wdata   (mem_dout),
      .rdata_c (fifo_rdata_c),
      .full_c  (fifo_full_c),
      .empty_c (fifo_empty_c),
      .count   (fifo_count)
   );

   // Next state plus the unpack/flow-control strobes for this cycle.
   always_comb begin
      state_next = state;
      accept_c   = (state == ST_IDLE) && vga_cs && (vga_acc == ACC_BURST) && (vga_burst != '0);
      bad_req_c  = vga_cs && !accept_c;
      ack_in_c   = mem_ack && (state == ST_STREAM);
      overflow_c = ack_in_c && fifo_full_c;
      // An empty FIFO forwards the arriving word so the first write lands one cycle after mem_ack.
      head_c     = fifo_empty_c ? mem_dout : fifo_rdata_c;
      avail_c    = ((state == ST_STREAM) || (state == ST_DRAIN)) && (!fifo_empty_c || ack_in_c);
      wr_c       = avail_c && (pix_left != '0);
      pop_c      = wr_c && (half_sel || (pix_left == BURST_W'(1)));
      fifo_pop_c = pop_c && !fifo_empty_c;
      fifo_push_c = ack_in_c && !(fifo_empty_c && pop_c);
      occ_next_c = fifo_count + CNT_W'(fifo_push_c && !fifo_full_c) - CNT_W'(fifo_pop_c);
      stall_c    = (occ_next_c >= CNT_W'(FIFO_DEPTH - 1));

      unique case (state)
         ST_IDLE:   if (accept_c) state_next = ST_REQ;
         ST_REQ:    state_next = ST_STREAM;
         ST_STREAM: if (ack_in_c && ((word_cnt + BURST_W'(1)) == req.burst)) state_next = ST_DRAIN;
         ST_DRAIN:  if (fifo_empty_c) state_next = ST_DONE;
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Registered outputs, request latch, counters and half-select.
   always_ff @(posedge clk) begin
      if (res) begin
         req           <= '0;
         word_cnt      <= '0;
         pix_left      <= '0;
         wr_ptr        <= '0;
         half_sel      <= 1'b0;
         vga_ack       <= 1'b0;
         mem_cs        <= 1'b0;
         mem_stall     <= 1'b0;
         high_ram_addr <= '0;
         high_ram_din  <= '0;
         high_ram_wr   <= 1'b0;
         busy          <= 1'b0;
         err           <= 1'b0;
      end else begin
         mem_cs      <= (state_next == ST_REQ);
         vga_ack     <= (state_next == ST_DONE);
         busy        <= (state_next != ST_IDLE);
         mem_stall   <= stall_c;
         high_ram_wr <= wr_c;
         if (bad_req_c || overflow_c) err <= 1'b1;
         if (accept_c) begin
            req      <= '{acc: ACC_BURST, addr: vga_addr >> 1, burst: words_for(vga_burst)};
            word_cnt <= '0;
            pix_left <= vga_burst;
            wr_ptr   <= '0;
            half_sel <= 1'b0;
         end
         if (ack_in_c) word_cnt <= word_cnt + BURST_W'(1);
         if (wr_c) begin
            high_ram_addr <= wr_ptr;
            high_ram_din  <= half_sel ? head_c[PIX_W-1:0] : head_c[WORD_W-1:PIX_W];
            wr_ptr        <= wr_ptr + LB_AW'(1);
            pix_left      <= pix_left - BURST_W'(1);
            half_sel      <= !pop_c;
         end
      end
   end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: a scripted memory model feeds bursts
// and a monitor logs every line-buffer write for comparison.
module tb_vga_line_fetch;
   import vga_line_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        res, vga_cs, vga_ack, mem_cs, mem_ack, mem_stall;
   logic        high_ram_wr, busy, err;
   logic [31:0] vga_addr, mem_addr, mem_dout;
   logic [1:0]  vga_acc, mem_acc;
   logic [8:0]  vga_burst, mem_burst, high_ram_addr;
   logic [15:0] high_ram_din;

   vga_line_fetch dut (
      .clk(clk), .res(res), .vga_cs(vga_cs), .vga_addr(vga_addr), .vga_acc(vga_acc),
      .vga_burst(vga_burst), .vga_ack(vga_ack), .mem_cs(mem_cs), .mem_addr(mem_addr),
      .mem_acc(mem_acc), .mem_burst(mem_burst), .mem_dout(mem_dout), .mem_ack(mem_ack),
      .mem_stall(mem_stall), .high_ram_addr(high_ram_addr), .high_ram_din(high_ram_din),
      .high_ram_wr(high_ram_wr), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [31:0] wtab [256];
   logic [8:0]  wq_addr [$];
   logic [15:0] wq_data [$];
   int   ack_cnt = 0, mcs_cnt = 0, stall_rises = 0, cyc_n = 0;
   int   first_ack_cyc = -1, first_wr_cyc = -1, last_wr_cyc = 0, ack_cyc = 0;
   logic stall_q = 1'b0;

   // Monitor: log writes, strobes and timing, sampled on the falling edge.
   always @(negedge clk) begin
      cyc_n++;
      if (mem_cs) begin
         mcs_cnt++;
         first_ack_cyc = -1;
         first_wr_cyc  = -1;
      end
      if (high_ram_wr) begin
         wq_addr.push_back(high_ram_addr);
         wq_data.push_back(high_ram_din);
         if (first_wr_cyc < 0) first_wr_cyc = cyc_n;
         last_wr_cyc = cyc_n;
      end
      if (mem_ack && busy && first_ack_cyc < 0) first_ack_cyc = cyc_n;
      if (vga_ack) begin
         ack_cnt++;
         ack_cyc = cyc_n;
      end
      if (mem_stall && !stall_q) stall_rises++;
      stall_q = mem_stall;
   end

   task automatic fill_tab(input int seed);
      for (int i = 0; i < 256; i++)
         wtab[i] = {16'(seed + 14 * i), 16'(seed + 14 * i + 7)};
   endtask

   task automatic do_reset();
      res = 1'b1;
      repeat (2) @(posedge clk);
      #1 res = 1'b0;
   endtask

   // mode 0: ack every 2nd cycle; 1: honour mem_stall; 2: ack every cycle regardless.
   task automatic run_line(input string tag, input logic [31:0] addr, input int burst,
                           input int mode, input int abort_after, input int cs_at);
      int   nwords;
      int   sent;
      int   cyc;
      int   want;
      logic stall_prev;
      nwords = (burst + 1) / 2;
      want   = (nwords < abort_after) ? nwords : abort_after;
      sent   = 0;
      cyc    = 0;
      @(posedge clk);
      #1 vga_addr = addr; vga_burst = 9'(burst); vga_acc = ACC_BURST; vga_cs = 1'b1;
      @(posedge clk);
      #1 vga_cs = 1'b0;
      check({tag, "_mem_cs"}, 32'(mem_cs), 32'd1);
      @(posedge clk);
      #1 stall_prev = 1'b0;
      while (sent < want && cyc < 4000) begin
         vga_cs = (cyc == cs_at);
         case (mode)
            0:       mem_ack = (cyc % 2 == 1);
            1:       mem_ack = !stall_prev;
            default: mem_ack = 1'b1;
         endcase
         mem_dout = wtab[sent];
         if (mem_ack) sent++;
         stall_prev = mem_stall;
         @(posedge clk);
         #1 cyc++;
      end
      mem_ack = 1'b0;
      vga_cs  = 1'b0;
      check({tag, "_words_sent"}, 32'(sent), 32'(want));
   endtask

   task automatic wait_ack(input string tag, input int base);
      int n;
      n = 0;
      while (ack_cnt == base && n < 3000) begin
         @(posedge clk);
         #1 n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_ack_count"}, 32'(ack_cnt - base), 32'd1);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   task automatic check_pixels(input string tag, input int wbase, input int burst);
      int          n;
      int          bad;
      logic [15:0] exp;
      n   = wq_addr.size() - wbase;
      bad = 0;
      check({tag, "_write_count"}, 32'(n), 32'(burst));
      for (int i = 0; i < n; i++) begin
         exp = (i % 2 == 0) ? wtab[i / 2][31:16] : wtab[i / 2][15:0];
         if (wq_addr[wbase + i] !== 9'(i) || wq_data[wbase + i] !== exp) bad++;
      end
      check({tag, "_pixel_errors"}, 32'(bad), 32'd0);
   endtask

   int wb, ab, mb, sb;

   initial begin
      res = 1'b1; vga_cs = 1'b0; vga_addr = '0; vga_acc = '0; vga_burst = '0;
      mem_dout = '0; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_mem_cs", 32'(mem_cs), 32'd0);
      check("rst_wr", 32'(high_ram_wr), 32'd0);
      check("rst_stall", 32'(mem_stall), 32'd0);
      check("rst_mem_acc", 32'(mem_acc), 32'd0);
      res = 1'b0;

      // 320-pixel line, ack every 2nd cycle
      fill_tab(16'h1000);
      wb = wq_addr.size(); ab = ack_cnt;
      run_line("t1", 32'h00FD_A800, 320, 0, 1000, -1);
      check("t1_mem_addr", mem_addr, 32'h007E_D400);
      check("t1_mem_burst", 32'(mem_burst), 32'd160);
      check("t1_mem_acc", 32'(mem_acc), 32'(ACC_BURST));
      wait_ack("t1", ab);
      check_pixels("t1", wb, 320);
      check("t1_err", 32'(err), 32'd0);
      check("t1_first_wr_latency", 32'(first_wr_cyc - first_ack_cyc), 32'd1);
      check("t1_ack_latency", 32'(ack_cyc - last_wr_cyc), 32'd1);

      // odd burst: low half of the last word is discarded
      wtab[0] = 32'hAAAA_BBBB; wtab[1] = 32'hCCCC_DDDD;
      wb = wq_addr.size(); ab = ack_cnt;
      run_line("t2", 32'h0000_0100, 3, 0, 1000, -1);
      check("t2_mem_burst", 32'(mem_burst), 32'd2);
      wait_ack("t2", ab);
      check_pixels("t2", wb, 3);

      // single-pixel burst
      wtab[0] = 32'h1234_5678;
      wb = wq_addr.size(); ab = ack_cnt;
      run_line("t2b", 32'h0000_0200, 1, 0, 1000, -1);
      check("t2b_mem_burst", 32'(mem_burst), 32'd1);
      wait_ack("t2b", ab);
      check_pixels("t2b", wb, 1);

      // back-to-back acks with memory honouring mem_stall
      fill_tab(16'h3000);
      wb = wq_addr.size(); ab = ack_cnt; sb = stall_rises;
      run_line("t3", 32'h0000_0000, 320, 1, 1000, -1);
      wait_ack("t3", ab);
      check_pixels("t3", wb, 320);
      check("t3_stall_toggled", 32'(stall_rises > sb), 32'd1);
      check("t3_err", 32'(err), 32'd0);

      // memory ignores mem_stall: overflow
      do_reset();
      fill_tab(16'h4000);
      wb = wq_addr.size(); ab = ack_cnt;
      run_line("t4", 32'h0000_0040, 16, 2, 1000, -1);
      wait_ack("t4", ab);
      check("t4_err", 32'(err), 32'd1);
      check("t4_fewer_writes", 32'((wq_addr.size() - wb) < 16), 32'd1);

      // second request while streaming
      do_reset();
      fill_tab(16'h5000);
      wb = wq_addr.size(); ab = ack_cnt; mb = mcs_cnt;
      run_line("t5", 32'h0000_0800, 320, 0, 1000, 20);
      wait_ack("t5", ab);
      check("t5_err", 32'(err), 32'd1);
      check("t5_mem_cs_count", 32'(mcs_cnt - mb), 32'd1);
      check_pixels("t5", wb, 320);

      // reset mid-fetch, stray acks, then a fresh line
      do_reset();
      fill_tab(16'h6000);
      run_line("t6a", 32'h0000_1000, 320, 0, 50, -1);
      check("t6_busy_mid", 32'(busy), 32'd1);
      do_reset();
      check("t6_busy_reset", 32'(busy), 32'd0);
      wb = wq_addr.size(); ab = ack_cnt;
      mem_ack = 1'b1; mem_dout = 32'hDEAD_BEEF;
      repeat (10) @(posedge clk);
      #1 mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("t6_stray_writes", 32'(wq_addr.size() - wb), 32'd0);
      check("t6_stray_acks", 32'(ack_cnt - ab), 32'd0);
      check("t6_err_cleared", 32'(err), 32'd0);
      wb = wq_addr.size(); ab = ack_cnt;
      run_line("t6b", 32'h0000_1000, 320, 0, 1000, -1);
      wait_ack("t6b", ab);
      check_pixels("t6b", wb, 320);

      // bad access type, then zero-length burst
      do_reset();
      ab = ack_cnt; mb = mcs_cnt;
      @(posedge clk);
      #1 vga_acc = 2'(ACC_BURST + 2'd1); vga_burst = 9'd8; vga_cs = 1'b1;
      @(posedge clk);
      #1 vga_cs = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t7_bad_acc_err", 32'(err), 32'd1);
      check("t7_bad_acc_busy", 32'(busy), 32'd0);
      check("t7_bad_acc_mem_cs", 32'(mcs_cnt - mb), 32'd0);
      do_reset();
      @(posedge clk);
      #1 vga_acc = ACC_BURST; vga_burst = 9'd0; vga_cs = 1'b1;
      @(posedge clk);
      #1 vga_cs = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t7_zero_err", 32'(err), 32'd1);
      check("t7_zero_mem_cs", 32'(mcs_cnt - mb), 32'd0);
      check("t7_no_ack", 32'(ack_cnt - ab), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
